jk_cmd_arbiter: RTL

Round-robin arbiter and sequencer that shares one bank of WIDTH JK flip-flops between NREQ requesters. Each requester posts a JK command (hold/reset/set/toggle) and a bit mask. The block grants one requester at a time and drives the bank's J/K inputs for exactly one cycle. It then checks the bank's Q feedback against the expected result and reports completion and error per request.

---
 rtl/jk_cmd_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/jk_cmd_arbiter.sv
// Round-robin arbiter that sequences JK commands from NREQ requesters onto one shared
// JK flip-flop bank, then verifies the bank's Q feedback against the predicted result.
module jk_cmd_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       cmd,
  input  logic [WIDTH*NREQ-1:0]   mask,
  input  logic [WIDTH-1:0]        q_fb,
  output logic [WIDTH-1:0]        j_out,
  output logic [WIDTH-1:0]        k_out,
  output logic                    jk_en,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    err,
  output logic                    busy
);

  localparam int unsigned PW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] cmd_val;

  logic             found;
  logic [PW-1:0]    win_sel;
  logic [PW-1:0]    idx;

  // First requester at or after ptr_q, wrapping upward.
  always_comb begin
    found   = 1'b0;
    win_sel = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PW'((32'(ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_sel = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      cmd_q   <= '0;
      mask_q  <= '0;
      snap_q  <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      cmd_q   <= cmd_d;
      mask_q  <= mask_d;
      snap_q  <= snap_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    unique case (cmd_q)
      2'b00:   cmd_val = snap_q;
      2'b01:   cmd_val = '0;
      2'b10:   cmd_val = '1;
      default: cmd_val = ~snap_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    cmd_d   = cmd_q;
    mask_d  = mask_q;
    snap_d  = snap_q;
    exp_d   = exp_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = win_sel;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_sel;
          cmd_d   = cmd[32'(win_sel)*2 +: 2];
          mask_d  = mask[32'(win_sel)*WIDTH +: WIDTH];
          snap_d  = q_fb;
          state_d = StDrive;
        end
      end
      StDrive: begin
        exp_d   = (snap_q & ~mask_q) | (cmd_val & mask_q);
        state_d = StCheck;
      end
      StCheck: begin
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Enable is gated by reset so an abort in DRIVE never reaches the bank.
  always_comb begin
    busy  = (state_q != StIdle);
    jk_en = (state_q == StDrive) && rst;
    j_out = jk_en ? (mask_q & {WIDTH{cmd_q[1]}}) : '0;
    k_out = jk_en ? (mask_q & {WIDTH{cmd_q[0]}}) : '0;
    gnt   = gnt_q;
    done  = (state_q == StCheck) ? gnt_q : '0;
    err   = (state_q == StCheck) && (q_fb != exp_q);
  end

endmodule
